// File: rtl/piece_sprite_pipe.sv
// Chess-piece sprite renderer: frame-latched placement, sprite ROM addressing,
// latency-matched palette lookup and a blinking inverse-colour highlight.
module piece_sprite_pipe #(
    parameter  int SPRITE_DIM   = 55,
    parameter  int NUM_TYPES    = 6,
    parameter  int IDX_W        = 4,
    parameter  int COLOR_W      = 4,
    parameter  int ROM_LAT      = 1,
    parameter  int TRANSP_IDX   = 0,
    parameter  int BLINK_FRAMES = 30,
    localparam int TYPE_W       = (NUM_TYPES > 1) ? $clog2(NUM_TYPES) : 1,
    localparam int ADDR_W       = $clog2(SPRITE_DIM * SPRITE_DIM)
) (
    input  logic               vga_clk,
    input  logic               Reset_n,
    input  logic               frame_start,
    input  logic [9:0]         DrawX,
    input  logic [9:0]         DrawY,
    input  logic [9:0]         offsetX,
    input  logic [9:0]         offsetY,
    input  logic [TYPE_W-1:0]  piece_type,
    input  logic               mirror,
    input  logic               highlight,
    output logic [ADDR_W-1:0]  rom_addr,
    output logic [TYPE_W-1:0]  rom_sel,
    input  logic [IDX_W-1:0]   rom_idx,
    output logic [TYPE_W-1:0]  pal_sel,
    output logic [IDX_W-1:0]   pal_idx,
    input  logic [COLOR_W-1:0] pal_red,
    input  logic [COLOR_W-1:0] pal_green,
    input  logic [COLOR_W-1:0] pal_blue,
    output logic [COLOR_W-1:0] red,
    output logic [COLOR_W-1:0] green,
    output logic [COLOR_W-1:0] blue,
    output logic               sprite_on
);

    localparam logic [9:0]        DIM_M1   = 10'(SPRITE_DIM - 1);
    localparam logic [TYPE_W:0]   NT       = (TYPE_W + 1)'(NUM_TYPES);
    localparam logic [IDX_W-1:0]  TRANSP   = IDX_W'(TRANSP_IDX);
    localparam int                CNT_W    = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(BLINK_FRAMES - 1);

    logic [TYPE_W-1:0]  type_q, type_d;
    logic               mirror_q, mirror_d;
    logic               hl_q, hl_d;
    logic [9:0]         offx_q, offx_d;
    logic [9:0]         offy_q, offy_d;

    logic [9:0]         dx_p0, dy_p0, col_p0;
    logic               in_box_p0;
    logic [ADDR_W-1:0]  addr_p0;

    logic [ADDR_W-1:0]  rom_addr_q;
    logic [TYPE_W-1:0]  rom_sel_q;
    logic               in_box_p1_q;

    logic               in_box_dly_q [ROM_LAT];
    logic [TYPE_W-1:0]  type_dly_q   [ROM_LAT];

    logic [COLOR_W-1:0] red_q, red_d, green_q, green_d, blue_q, blue_d;
    logic               sprite_on_q, sprite_on_d;
    logic               opaque, blink_on;
    logic [COLOR_W-1:0] inv_mask;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               ph_q, ph_d;

    // The _d shadow values double as this cycle's geometry, so a pixel that
    // coincides with frame_start already sees the new frame's placement.
    always_comb begin
        type_d   = type_q;
        mirror_d = mirror_q;
        hl_d     = hl_q;
        offx_d   = offx_q;
        offy_d   = offy_q;
        if (frame_start) begin
            type_d   = ({1'b0, piece_type} < NT) ? piece_type : '0;
            mirror_d = mirror;
            hl_d     = highlight;
            offx_d   = offsetX;
            offy_d   = offsetY;
        end
    end

    // Stage 0: bounds test and address math
    always_comb begin
        dx_p0     = DrawX - offx_d;
        dy_p0     = DrawY - offy_d;
        in_box_p0 = (DrawX >= offx_d) && (dx_p0 <= DIM_M1) &&
                    (DrawY >= offy_d) && (dy_p0 <= DIM_M1);
        col_p0    = mirror_d ? (DIM_M1 - dx_p0) : dx_p0;
        addr_p0   = '0;
        if (in_box_p0) begin
            addr_p0 = ADDR_W'(col_p0) + ADDR_W'(dy_p0) * ADDR_W'(SPRITE_DIM);
        end
    end

    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            type_q      <= '0;
            mirror_q    <= 1'b0;
            hl_q        <= 1'b0;
            offx_q      <= '0;
            offy_q      <= '0;
            rom_addr_q  <= '0;
            rom_sel_q   <= '0;
            in_box_p1_q <= 1'b0;
        end else begin
            type_q      <= type_d;
            mirror_q    <= mirror_d;
            hl_q        <= hl_d;
            offx_q      <= offx_d;
            offy_q      <= offy_d;
            // Stage 1: registered ROM request
            rom_addr_q  <= addr_p0;
            rom_sel_q   <= type_d;
            in_box_p1_q <= in_box_p0;
        end
    end

    // Stage 2..ROM_LAT+1: carry in_box and type alongside the ROM access
    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                in_box_dly_q[i] <= 1'b0;
                type_dly_q[i]   <= '0;
            end
        end else begin
            in_box_dly_q[0] <= in_box_p1_q;
            type_dly_q[0]   <= rom_sel_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                in_box_dly_q[i] <= in_box_dly_q[i-1];
                type_dly_q[i]   <= type_dly_q[i-1];
            end
        end
    end

    // Output stage: transparency and blink inversion
    always_comb begin
        blink_on    = hl_q & ph_q;
        inv_mask    = {COLOR_W{blink_on}};
        opaque      = in_box_dly_q[ROM_LAT-1] && (rom_idx != TRANSP);
        sprite_on_d = opaque;
        red_d       = '0;
        green_d     = '0;
        blue_d      = '0;
        if (opaque) begin
            red_d   = pal_red   ^ inv_mask;
            green_d = pal_green ^ inv_mask;
            blue_d  = pal_blue  ^ inv_mask;
        end
    end

    // Counter restarts whenever highlight is off, so every highlight episode
    // begins with a full un-inverted half-period.
    always_comb begin
        cnt_d = cnt_q;
        ph_d  = ph_q;
        if (!hl_q) begin
            cnt_d = '0;
            ph_d  = 1'b0;
        end else if (frame_start) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                ph_d  = ~ph_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge vga_clk or negedge Reset_n) begin
        if (!Reset_n) begin
            red_q       <= '0;
            green_q     <= '0;
            blue_q      <= '0;
            sprite_on_q <= 1'b0;
            cnt_q       <= '0;
            ph_q        <= 1'b0;
        end else begin
            red_q       <= red_d;
            green_q     <= green_d;
            blue_q      <= blue_d;
            sprite_on_q <= sprite_on_d;
            cnt_q       <= cnt_d;
            ph_q        <= ph_d;
        end
    end

    assign rom_addr  = rom_addr_q;
    assign rom_sel   = rom_sel_q;
    assign pal_sel   = type_dly_q[ROM_LAT-1];
    assign pal_idx   = rom_idx;
    assign red       = red_q;
    assign green     = green_q;
    assign blue      = blue_q;
    assign sprite_on = sprite_on_q;

endmodule

// File: doc/piece_sprite_pipe.md
PIECE_SPRITE_PIPE -- requirements
Module: piece_sprite_pipe

Interface
REQ-001 The block SHALL have parameter SPRITE_DIM, default 55, meaning sprite width and height in pixels.
REQ-002 The block SHALL have parameter NUM_TYPES, default 6, meaning number of selectable piece sprites (pawn, knight, bishop, rook, queen, king).
REQ-003 The block SHALL have parameter IDX_W, default 4, meaning palette index width.
REQ-004 The block SHALL have parameter COLOR_W, default 4, meaning per-channel colour width.
REQ-005 The block SHALL have parameter ROM_LAT, default 1, meaning external ROM read latency in vga_clk cycles, with a legal range of 1..3.
REQ-006 The block SHALL have parameter TRANSP_IDX, default 0, meaning the palette index treated as transparent.
REQ-007 The block SHALL have parameter BLINK_FRAMES, default 30, meaning frames per blink half-period.
REQ-008 The block SHALL have the following ports:
- vga_clk  in  1  pixel clock, the single clock.
- Reset_n  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse at the first pixel of a frame.
- DrawX, DrawY  in  10 each  current pixel coordinate.
- offsetX, offsetY  in  10 each  sprite top-left corner.
- piece_type  in  clog2(NUM_TYPES)  requested sprite.
- mirror  in  1  horizontal flip request.
- highlight  in  1  blink-highlight request.
- rom_addr  out  clog2(SPRITE_DIM^2)  ROM address.
- rom_sel  out  clog2(NUM_TYPES)  ROM bank select.
- rom_idx  in  IDX_W  ROM data, valid ROM_LAT cycles after rom_addr.
- pal_sel  out  clog2(NUM_TYPES)  palette bank select.
- pal_idx  out  IDX_W  palette index.
- pal_red, pal_green, pal_blue  in  COLOR_W each  combinational palette output.
- red, green, blue  out  COLOR_W each  registered pixel colour.
- sprite_on  out  1  pixel is an opaque sprite pixel.

Function
REQ-009 Frame latching: piece_type, mirror, highlight, offsetX and offsetY SHALL be captured into shadow registers only on the cycle frame_start=1, and these shadow values SHALL be used for the entire frame, so that no mid-frame tearing occurs.
REQ-010 Stage 0 bounds test: in_box SHALL be 1 iff DrawX>=offX, DrawX-offX<=SPRITE_DIM-1, DrawY>=offY and DrawY-offY<=SPRITE_DIM-1, with explicit unsigned comparisons and no wrap-around acceptance.
REQ-011 Column address: col SHALL be DrawX-offX when mirror=0, and SPRITE_DIM-1-(DrawX-offX) when mirror=1.
REQ-012 Stage 1 ROM address: rom_addr SHALL be registered as col + row*SPRITE_DIM when in_box=1, and as 0 otherwise; rom_sel SHALL be registered as the shadow piece_type.
REQ-013 Type pipeline: in_box and the shadow type SHALL be delayed through a shift pipeline of ROM_LAT stages so that they align with rom_idx.
REQ-014 Palette lookup: pal_sel SHALL equal the delayed type, and pal_idx SHALL equal rom_idx, both combinationally.
REQ-015 Output stage: on each vga_clk edge the block SHALL register sprite_on = delayed in_box AND (rom_idx != TRANSP_IDX).
REQ-016 Output colour: when sprite_on=1, the block SHALL register pal_* as the colour, or its bitwise inverse when the blink phase is active.
REQ-017 Output colour when transparent: when sprite_on=0, red, green and blue SHALL be registered as 0.
REQ-018 Latency: total latency from DrawX/DrawY to red/green/blue/sprite_on SHALL be ROM_LAT+2 cycles, fully pipelined at one pixel per cycle.
REQ-019 Blink counter: the frame counter SHALL increment on frame_start and wrap to 0 after BLINK_FRAMES-1, at which point blink_ph SHALL toggle.
REQ-020 Blink phase: the blink phase SHALL be active iff the shadow highlight=1 AND blink_ph=1.
REQ-021 Highlight clear: when the shadow highlight=0, the block SHALL hold blink_ph at 0 so that the next highlight starts un-inverted.
REQ-022 Illegal type: a piece_type >= NUM_TYPES SHALL latch as 0.
REQ-023 Simultaneous events: if frame_start and a box-edge pixel occur in the same cycle, that pixel SHALL use the new shadow values.

Reset
REQ-024 While Reset_n=0, the block SHALL clear all pipeline registers, shadow registers, the blink counter and blink_ph, and SHALL drive rom_addr=0, rom_sel=0, red/green/blue=0 and sprite_on=0.
REQ-025 Reset assertion mid-frame SHALL take effect immediately and asynchronously.
REQ-026 After Reset_n is released, outputs SHALL stay 0 until the pipeline refills, and the shadow registers SHALL remain at type 0 with no mirror until the first frame_start.

Verification
REQ-027 The bench SHALL cover a corner test: offset=(100,100), DrawX=100..154 -> sprite_on rises at ROM_LAT+2 cycles after DrawX=100 and falls after DrawX=154; DrawX=99 and DrawX=155 -> sprite_on=0.
REQ-028 The bench SHALL cover a wrap test: offset=(1000,0) with DrawX=5 -> sprite_on=0, and no false hit from unsigned wrap.
REQ-029 The bench SHALL cover a mirror test: mirror=1, offset 0, DrawY=0, DrawX=0 -> rom_addr=54; DrawX=54 -> rom_addr=0.
REQ-030 The bench SHALL cover a tear test: piece_type changes from 0 to 4 mid-frame -> rom_sel stays 0 until the cycle after the next frame_start, then becomes 4.
REQ-031 The bench SHALL cover a blink test: highlight=1 with pal_red=0xA -> red=0xA for frames 0..29 and red=0x5 for frames 30..59; transparent rom_idx=0 -> red=0 and sprite_on=0.
REQ-032 The bench SHALL cover a reset test: Reset_n pulled low mid-line -> all outputs 0 within the same cycle; after release, type 0 is shown until the first frame_start.
